// File: rtl/hci_package.sv
// hci_package: HCI-Core payload layouts and width helpers shared by the register slice.
package hci_package;
    localparam int unsigned HCI_AW = 32;
    localparam int unsigned HCI_DW = 32;
    localparam int unsigned HCI_UW = 1;
    typedef struct packed {
        logic [HCI_AW-1:0]   add;
        logic                wen;
        logic [HCI_DW-1:0]   data;
        logic [HCI_DW/8-1:0] be;
        logic [HCI_UW-1:0]   user;
    } hci_req_t;
    typedef struct packed {
        logic [HCI_DW-1:0] r_data;
        logic [HCI_UW-1:0] r_user;
    } hci_rsp_t;
    function automatic int unsigned hci_req_width(input int unsigned aw, input int unsigned dw, input int unsigned uw);
        return aw + 1 + dw + dw / 8 + uw;
    endfunction
    function automatic int unsigned hci_rsp_width(input int unsigned dw, input int unsigned uw);
        return dw + uw;
    endfunction
endpackage

// File: rtl/hci_core_intf.sv
// hci_core_intf: HCI-Core request/response bundle with target and initiator views.
interface hci_core_intf #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter int unsigned UW = 1
) ();
    logic          req;
    logic          gnt;
    logic [AW-1:0] add;
    logic          wen;
    logic [DW-1:0] data;
    logic [DW/8-1:0] be;
    logic [UW-1:0] user;
    logic          r_ready;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic [UW-1:0] r_user;
    modport target (input req, add, wen, data, be, user, r_ready, output gnt, r_data, r_valid, r_user);
    modport initiator (output req, add, wen, data, be, user, r_ready, input gnt, r_data, r_valid, r_user);
endinterface

// File: rtl/hci_core_skid_buffer.sv
// hci_core_skid_buffer: 2-entry valid/ready slice; handshake outputs depend only on occupancy.
module hci_core_skid_buffer #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [1:0]   cnt, cnt_n;
    logic [W-1:0] head, tail, head_n, tail_n;
    logic         push, pop;
    assign in_ready  = cnt != 2'd2;
    assign out_valid = cnt != 2'd0;
    assign out_data  = head;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // head always holds the oldest entry; tail is only used when both are occupied
    always_comb begin
        cnt_n  = cnt + {1'b0, push} - {1'b0, pop};
        head_n = (pop && cnt == 2'd2) ? tail : (push && (cnt == 2'd0 || pop)) ? in_data : head;
        tail_n = (push && !pop && cnt == 2'd1) ? in_data : tail;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt  <= '0;
            head <= '0;
            tail <= '0;
        end else if (clear_i) begin
            cnt  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            cnt  <= cnt_n;
            head <= head_n;
            tail <= tail_n;
        end
    end
endmodule

// File: rtl/hci_core_reg_slice.sv
// hci_core_reg_slice: per-channel optional request/response register slices between HCI-Core ports.
module hci_core_reg_slice
    import hci_package::*;
#(
    parameter int unsigned N_CH    = 1,
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned UW      = 1,
    parameter int unsigned REQ_CUT = 1,
    parameter int unsigned RSP_CUT = 1
) (
    input logic clk_i,
    input logic rst_ni,
    input logic clear_i,
    hci_core_intf.target    tcdm_target    [N_CH],
    hci_core_intf.initiator tcdm_initiator [N_CH]
);
    localparam int unsigned REQ_W = hci_req_width(AW, DW, UW);
    localparam int unsigned RSP_W = hci_rsp_width(DW, UW);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        if (REQ_CUT != 0) begin : g_req_cut
            logic [REQ_W-1:0] req_in, req_out;
            assign req_in = {tcdm_target[i].add, tcdm_target[i].wen, tcdm_target[i].data,
                             tcdm_target[i].be, tcdm_target[i].user};
            assign {tcdm_initiator[i].add, tcdm_initiator[i].wen, tcdm_initiator[i].data,
                    tcdm_initiator[i].be, tcdm_initiator[i].user} = req_out;
            hci_core_skid_buffer #(.W(REQ_W)) i_req_slice (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .clear_i   (clear_i),
                .in_valid  (tcdm_target[i].req),
                .in_ready  (tcdm_target[i].gnt),
                .in_data   (req_in),
                .out_valid (tcdm_initiator[i].req),
                .out_ready (tcdm_initiator[i].gnt),
                .out_data  (req_out)
            );
        end else begin : g_req_pass
            assign tcdm_initiator[i].req  = tcdm_target[i].req;
            assign tcdm_target[i].gnt     = tcdm_initiator[i].gnt;
            assign tcdm_initiator[i].add  = tcdm_target[i].add;
            assign tcdm_initiator[i].wen  = tcdm_target[i].wen;
            assign tcdm_initiator[i].data = tcdm_target[i].data;
            assign tcdm_initiator[i].be   = tcdm_target[i].be;
            assign tcdm_initiator[i].user = tcdm_target[i].user;
        end
        if (RSP_CUT != 0) begin : g_rsp_cut
            logic [RSP_W-1:0] rsp_in, rsp_out;
            assign rsp_in = {tcdm_initiator[i].r_data, tcdm_initiator[i].r_user};
            assign {tcdm_target[i].r_data, tcdm_target[i].r_user} = rsp_out;
            hci_core_skid_buffer #(.W(RSP_W)) i_rsp_slice (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .clear_i   (clear_i),
                .in_valid  (tcdm_initiator[i].r_valid),
                .in_ready  (tcdm_initiator[i].r_ready),
                .in_data   (rsp_in),
                .out_valid (tcdm_target[i].r_valid),
                .out_ready (tcdm_target[i].r_ready),
                .out_data  (rsp_out)
            );
        end else begin : g_rsp_pass
            assign tcdm_target[i].r_valid    = tcdm_initiator[i].r_valid;
            assign tcdm_initiator[i].r_ready = tcdm_target[i].r_ready;
            assign tcdm_target[i].r_data     = tcdm_initiator[i].r_data;
            assign tcdm_target[i].r_user     = tcdm_initiator[i].r_user;
        end
    end
endmodule
